// File: rtl/keypad_time_entry.sv
// keypad_time_entry
//   Front end of the microwave controller. It synchronises and debounces the
//   one-hot 10-key keypad. Each accepted press is shifted, as a BCD digit, into
//   a three-digit cooking-time register (min : sec_tens : sec_ones). It also
//   produces a one-second tick, gated by the magnetron.
//
// Ports
//   clk         in   single rising-edge clock
//   clear       in   asynchronous active-high reset
//   keyboard    in   [9:0] raw one-hot keys (asynchronous to clk)
//   mag_on      in   magnetron active: blocks entry, enables the tick
//   min_d       out  [3:0] BCD minutes digit
//   sec_tens_d  out  [3:0] BCD seconds-tens digit
//   sec_ones_d  out  [3:0] BCD seconds-ones digit
//   loadn       out  active-low one-cycle strobe, digits just changed
//   time_valid  out  sec_tens_d <= 5 and at least one digit non-zero
//   pgt_1Hz     out  one-cycle tick every TICK_DIV cycles while mag_on
module keypad_time_entry #(
    parameter int DEBOUNCE = 4,
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keyboard,
    input  logic       mag_on,
    output logic [3:0] min_d,
    output logic [3:0] sec_tens_d,
    output logic [3:0] sec_ones_d,
    output logic       loadn,
    output logic       time_valid,
    output logic       pgt_1Hz
);

    localparam logic [7:0]  DEB_N     = 8'(DEBOUNCE);
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HELD, S_RELEASE} state_t;

    logic [9:0]  kb_meta_q, kb_s_q;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [9:0]  pat_q;
    logic [3:0]  idx_q;
    logic [3:0]  min_q, tens_q, ones_q;
    logic [3:0]  min_d_d, tens_d, ones_d;
    logic        loadn_q, tv_q, tv_d;
    logic [23:0] tick_cnt_q;
    logic        pgt_q;

    logic        kb_idle, kb_onehot, accept, shift;
    logic [3:0]  kb_idx;
    logic [7:0]  cnt_inc;

    always_comb begin
        kb_idle   = (kb_s_q == 10'd0);
        // A non-zero value with a single bit set clears to zero when ANDed with itself minus one.
        kb_onehot = !kb_idle && ((kb_s_q & (kb_s_q - 10'd1)) == 10'd0);
        kb_idx    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (kb_s_q[i]) kb_idx = 4'(i);
        end
        cnt_inc = cnt_q + 8'd1;
        accept  = (state_q == S_CHECK) && (kb_s_q == pat_q) && (cnt_inc == DEB_N);
        // mag_on is sampled on the accept edge itself.
        shift   = accept && !mag_on;
        min_d_d = shift ? tens_q : min_q;
        tens_d  = shift ? ones_q : tens_q;
        ones_d  = shift ? idx_q  : ones_q;
        tv_d    = (tens_d <= 4'd5) && ((min_d_d | tens_d | ones_d) != 4'd0);
    end

    // Two-flop synchroniser for the asynchronous keypad
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            kb_meta_q <= '0;
            kb_s_q    <= '0;
        end else begin
            kb_meta_q <= keyboard;
            kb_s_q    <= kb_meta_q;
        end
    end

    // Debounce FSM: a press and a release each need DEBOUNCE identical samples
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (kb_onehot) begin
                        pat_q   <= kb_s_q;
                        idx_q   <= kb_idx;
                        cnt_q   <= 8'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (kb_s_q == pat_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DEB_N) state_q <= S_HELD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HELD: begin
                    // Any other key pressed while one is held is ignored.
                    if (kb_idle) begin
                        cnt_q   <= 8'd1;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (kb_idle) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DEB_N) state_q <= S_IDLE;
                    end else begin
                        state_q <= S_HELD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Time-entry shift register and its registered status
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            loadn_q <= 1'b1;
            tv_q    <= 1'b0;
        end else begin
            min_q   <= min_d_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            loadn_q <= !shift;
            tv_q    <= tv_d;
        end
    end

    // Tick generator: the phase restarts from zero each time mag_on rises
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            tick_cnt_q <= '0;
            pgt_q      <= 1'b0;
        end else if (!mag_on) begin
            tick_cnt_q <= '0;
            pgt_q      <= 1'b0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            pgt_q      <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + 24'd1;
            pgt_q      <= 1'b0;
        end
    end

    assign min_d      = min_q;
    assign sec_tens_d = tens_q;
    assign sec_ones_d = ones_q;
    assign loadn      = loadn_q;
    assign time_valid = tv_q;
    assign pgt_1Hz    = pgt_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
module tb_keypad_time_entry;

    localparam int DEB  = 4;
    localparam int TDIV = 10;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keyboard;
    logic       mag_on;
    logic [3:0] min_d, sec_tens_d, sec_ones_d;
    logic       loadn, time_valid, pgt_1Hz;

    keypad_time_entry #(.DEBOUNCE(DEB), .TICK_DIV(TDIV)) dut (
        .clk        (clk),
        .clear      (clear),
        .keyboard   (keyboard),
        .mag_on     (mag_on),
        .min_d      (min_d),
        .sec_tens_d (sec_tens_d),
        .sec_ones_d (sec_ones_d),
        .loadn      (loadn),
        .time_valid (time_valid),
        .pgt_1Hz    (pgt_1Hz)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int at_edge;
        int m;
        int t;
        int o;
        int tv;
    } load_exp_t;

    typedef struct {
        int key;
        int m;
        int t;
        int o;
        int tv;
    } vec_t;

    load_exp_t load_q[$];
    int        tick_q[$];
    int        total = 0;
    int        bad   = 0;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_n);
        end
    endfunction

    // Scoreboard monitor: every loadn strobe and every tick is matched against the queues.
    load_exp_t le;
    int        te;
    always @(negedge clk) begin
        if (clear === 1'b0 && loadn === 1'b0) begin
            if (load_q.size() == 0) begin
                chk("unexpected_loadn", 1, 0);
            end else begin
                le = load_q.pop_front();
                chk("load_edge", edge_n, le.at_edge);
                chk("min_d", int'(min_d), le.m);
                chk("sec_tens_d", int'(sec_tens_d), le.t);
                chk("sec_ones_d", int'(sec_ones_d), le.o);
                chk("time_valid", int'(time_valid), le.tv);
            end
        end
        if (clear === 1'b0 && pgt_1Hz === 1'b1) begin
            if (tick_q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                te = tick_q.pop_front();
                chk("tick_edge", edge_n, te);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press a key expected to be accepted; the result appears DEB+2 edges after the drive edge.
    task automatic enter(input vec_t v);
        load_exp_t e;
        e.at_edge = edge_n + DEB + 2;
        e.m = v.m; e.t = v.t; e.o = v.o; e.tv = v.tv;
        load_q.push_back(e);
        keyboard = 10'd1 << v.key;
        tick(8);
        keyboard = '0;
        tick(8);
    endtask

    // Hand-computed digit sequence: key, then min, tens, ones, time_valid after the shift
    vec_t t1 [3] = '{'{1, 0,0,1, 1}, '{3, 0,1,3, 1}, '{0, 1,3,0, 1}};
    vec_t t4 [7] = '{'{1, 5,4,1, 1}, '{9, 4,1,9, 1}, '{0, 1,9,0, 0},
                     '{2, 9,0,2, 1}, '{9, 0,2,9, 1}, '{0, 2,9,0, 0},
                     '{4, 9,0,4, 1}};
    vec_t v2 = '{5, 3,0,5, 1};
    vec_t v3 = '{4, 0,5,4, 1};
    vec_t v6 = '{8, 0,0,8, 1};

    initial begin
        load_exp_t e;
        int        m;
        clear    = 1'b1;
        keyboard = '0;
        mag_on   = 1'b0;
        tick(3);
        chk("reset_min", int'(min_d), 0);
        chk("reset_tens", int'(sec_tens_d), 0);
        chk("reset_ones", int'(sec_ones_d), 0);
        chk("reset_loadn", int'(loadn), 1);
        chk("reset_tv", int'(time_valid), 0);
        chk("reset_pgt", int'(pgt_1Hz), 0);
        clear = 1'b0;
        tick(4);

        // Basic entry 1,3,0
        foreach (t1[i]) enter(t1[i]);

        // Bouncing key 5, then stable
        repeat (5) begin
            keyboard = 10'd1 << 5;
            tick(2);
            keyboard = '0;
            tick(2);
        end
        e.at_edge = edge_n + DEB + 2;
        e.m = v2.m; e.t = v2.t; e.o = v2.o; e.tv = v2.tv;
        load_q.push_back(e);
        keyboard = 10'd1 << 5;
        tick(10);
        keyboard = '0;
        tick(8);

        // Two keys at once: no event
        keyboard = (10'd1 << 2) | (10'd1 << 7);
        tick(8);
        keyboard = '0;
        tick(8);
        chk("multi_key_ones", int'(sec_ones_d), 5);

        // Key 4 held, then 9 pressed on top of it: only 4 counts
        e.at_edge = edge_n + DEB + 2;
        e.m = v3.m; e.t = v3.t; e.o = v3.o; e.tv = v3.tv;
        load_q.push_back(e);
        keyboard = 10'd1 << 4;
        tick(8);
        keyboard = (10'd1 << 4) | (10'd1 << 9);
        tick(6);
        keyboard = 10'd1 << 4;
        tick(2);
        keyboard = '0;
        tick(8);

        // Long entry shifting minutes out, time_valid around tens digit 9
        foreach (t4[i]) enter(t4[i]);

        // Tick with magnetron on; key 6 must be ignored
        m = edge_n + 1;
        tick_q.push_back(m + TDIV - 1);
        tick_q.push_back(m + 2 * TDIV - 1);
        tick_q.push_back(m + 3 * TDIV - 1);
        mag_on = 1'b1;
        tick(2);
        keyboard = 10'd1 << 6;
        tick(8);
        keyboard = '0;
        tick(8);
        tick(17);
        mag_on = 1'b0;
        chk("mag_on_ones", int'(sec_ones_d), 4);
        chk("mag_on_min", int'(min_d), 9);
        tick(25);

        // Clear in the middle of CHECK with key 8 held
        keyboard = 10'd1 << 8;
        tick(3);
        clear = 1'b1;
        #1;
        chk("midclr_min", int'(min_d), 0);
        chk("midclr_tens", int'(sec_tens_d), 0);
        chk("midclr_ones", int'(sec_ones_d), 0);
        chk("midclr_loadn", int'(loadn), 1);
        chk("midclr_tv", int'(time_valid), 0);
        tick(3);
        clear = 1'b0;
        e.at_edge = edge_n + DEB + 2;
        e.m = v6.m; e.t = v6.t; e.o = v6.o; e.tv = v6.tv;
        load_q.push_back(e);
        tick(12);
        keyboard = '0;
        tick(12);

        chk("load_queue_empty", load_q.size(), 0);
        chk("tick_queue_empty", tick_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
